// File: rtl/traffic_pkg.sv
// Shared codes, default durations and state encoding for the traffic interval timer.
package traffic_pkg;

    // Interval select codes (11 falls back to base)
    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    // Duration register select codes for programming writes
    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    // Power-on durations, in seconds
    localparam int unsigned DEF_T_BASE = 6;
    localparam int unsigned DEF_T_EXT  = 3;
    localparam int unsigned DEF_T_YEL  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COUNT  = 2'b01,
        EXPIRE = 2'b10
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Clearable modulo-TICK_DIV counter producing a one-cycle tick on wrap.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = en && (cnt_q == CNT_MAX);

    // Next count: clear wins, held at zero while disabled, wraps at TICK_DIV-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_interval_timer.sv
// Programmable phase-duration registers and seconds countdown for the traffic sequencer.
module traffic_interval_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned VAL_W    = 4,
    parameter int unsigned T_BASE   = DEF_T_BASE,
    parameter int unsigned T_EXT    = DEF_T_EXT,
    parameter int unsigned T_YEL    = DEF_T_YEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             prog_sync,
    input  logic [1:0]       time_param_sel,
    input  logic [VAL_W-1:0] time_value,
    input  logic             start_timer,
    input  logic [1:0]       interval,
    output logic             expired,
    output logic             one_hz,
    output logic [VAL_W-1:0] remaining,
    output logic             busy
);

    localparam logic [VAL_W-1:0] RST_BASE = VAL_W'(T_BASE);
    localparam logic [VAL_W-1:0] RST_EXT  = VAL_W'(T_EXT);
    localparam logic [VAL_W-1:0] RST_YEL  = VAL_W'(T_YEL);

    logic [VAL_W-1:0] base_q, base_d;
    logic [VAL_W-1:0] ext_q,  ext_d;
    logic [VAL_W-1:0] yel_q,  yel_d;

    timer_state_e     state_q, state_d;
    logic [VAL_W-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;
    logic             one_hz_q, one_hz_d;
    logic             busy_q, busy_d;

    logic             pre_clr_c;
    logic             pre_en_c;
    logic             tick_c;
    logic [VAL_W-1:0] sel_dur_c;

    assign pre_en_c = (state_q == COUNT);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (pre_clr_c),
        .en      (pre_en_c),
        .tick_c  (tick_c)
    );

    // Duration register writes; a zero value restores that register's default
    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (prog_sync) begin
            case (time_param_sel)
                SEL_BASE: base_d = (time_value == '0) ? RST_BASE : time_value;
                SEL_EXT:  ext_d  = (time_value == '0) ? RST_EXT  : time_value;
                SEL_YEL:  yel_d  = (time_value == '0) ? RST_YEL  : time_value;
                default:  ;
            endcase
        end
    end

    // Duration selected for a start request; the reserved code runs the base interval
    always_comb begin
        sel_dur_c = base_q;
        case (interval)
            INT_EXT: sel_dur_c = ext_q;
            INT_YEL: sel_dur_c = yel_q;
            default: sel_dur_c = base_q;
        endcase
    end

    // Next state and registered outputs: program abort, then start/restart, then countdown
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        one_hz_d    = 1'b0;
        pre_clr_c   = 1'b0;
        if (prog_sync) begin
            state_d     = IDLE;
            remaining_d = '0;
            pre_clr_c   = 1'b1;
        end else if (start_timer) begin
            state_d     = COUNT;
            remaining_d = sel_dur_c;
            pre_clr_c   = 1'b1;
        end else begin
            case (state_q)
                COUNT: begin
                    if (tick_c) begin
                        one_hz_d    = 1'b1;
                        remaining_d = remaining_q - VAL_W'(1);
                        if (remaining_q == VAL_W'(1)) begin
                            state_d = EXPIRE;
                        end
                    end
                end
                EXPIRE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        expired_d = (state_d == EXPIRE);
        busy_d    = (state_d == COUNT);
    end

    // State, countdown, duration and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            one_hz_q    <= 1'b0;
            busy_q      <= 1'b0;
            base_q      <= RST_BASE;
            ext_q       <= RST_EXT;
            yel_q       <= RST_YEL;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            one_hz_q    <= one_hz_d;
            busy_q      <= busy_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
        end
    end

    assign expired   = expired_q;
    assign one_hz    = one_hz_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Directed self-checking bench for traffic_interval_timer with TICK_DIV=4.
module tb_traffic_interval_timer;

    localparam int unsigned VAL_W = 4;

    logic             clk;
    logic             reset_n;
    logic             prog_sync;
    logic [1:0]       time_param_sel;
    logic [VAL_W-1:0] time_value;
    logic             start_timer;
    logic [1:0]       interval;
    logic             expired;
    logic             one_hz;
    logic [VAL_W-1:0] remaining;
    logic             busy;

    int n_compared;
    int n_mismatched;

    traffic_interval_timer #(
        .TICK_DIV (4),
        .VAL_W    (VAL_W),
        .T_BASE   (6),
        .T_EXT    (3),
        .T_YEL    (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .prog_sync      (prog_sync),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .start_timer    (start_timer),
        .interval       (interval),
        .expired        (expired),
        .one_hz         (one_hz),
        .remaining      (remaining),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_compared++;
        if (obs != exp_v) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] iv);
        start_timer = 1'b1;
        interval    = iv;
        step();
        start_timer = 1'b0;
    endtask

    task automatic program_reg(input logic [1:0] sel, input int val);
        prog_sync      = 1'b1;
        time_param_sel = sel;
        time_value     = VAL_W'(val);
        step();
        prog_sync      = 1'b0;
    endtask

    // Counts cycles from now to the first expired pulse, plus pulses seen in a bounded window
    task automatic wait_expire(input string tag, input int exp_cyc, input int exp_hz);
        int seen   = -1;
        int pulses = 0;
        int ticks  = 0;
        for (int c = 1; c <= exp_cyc + 3; c++) begin
            step();
            if (expired) begin
                pulses++;
                if (seen < 0) seen = c;
            end
            if (one_hz) ticks++;
        end
        check({tag, "_latency"}, seen, exp_cyc);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_one_hz"}, ticks, exp_hz);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_rem_after"}, int'(remaining), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_expired"}, int'(expired), 0);
        check({tag, "_one_hz"}, int'(one_hz), 0);
        check({tag, "_remaining"}, int'(remaining), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        n_compared     = 0;
        n_mismatched   = 0;
        reset_n        = 1'b0;
        prog_sync      = 1'b0;
        time_param_sel = 2'b00;
        time_value     = '0;
        start_timer    = 1'b0;
        interval       = 2'b00;

        // Reset state
        #12;
        check_zero_outputs("reset");
        step();
        reset_n = 1'b1;
        step();

        // Base start: 6 s at 4 cycles/s
        start(2'b00);
        check("base_busy_e0", int'(busy), 1);
        check("base_rem_e0", int'(remaining), 6);
        step(); step(); step();
        check("base_no_tick_c3", int'(one_hz), 0);
        step();
        check("base_tick_c4", int'(one_hz), 1);
        check("base_rem_c4", int'(remaining), 5);
        check("base_busy_c4", int'(busy), 1);
        wait_expire("base", 20, 5);

        // Program yellow to 5 s
        program_reg(2'b10, 5);
        start(2'b10);
        check("yel5_rem_e0", int'(remaining), 5);
        wait_expire("yel5", 20, 5);

        // Extended: write 7, then 0 restores default 3
        program_reg(2'b01, 7);
        program_reg(2'b01, 0);
        start(2'b01);
        check("ext_def_rem_e0", int'(remaining), 3);
        wait_expire("ext_def", 12, 3);

        // Reserved select writes nothing; base stays 6, reserved interval runs base
        program_reg(2'b11, 9);
        start(2'b11);
        check("rsvd_rem_e0", int'(remaining), 6);
        wait_expire("rsvd", 24, 6);

        // Restart while remaining = 2
        start(2'b01);
        step(); step(); step(); step();
        check("restart_rem_before", int'(remaining), 2);
        start(2'b01);
        check("restart_rem_reload", int'(remaining), 3);
        wait_expire("restart", 12, 3);

        // Abort with prog_sync mid-count
        start(2'b00);
        step(); step(); step(); step(); step();
        program_reg(2'b11, 1);
        check("abort_busy", int'(busy), 0);
        check("abort_rem", int'(remaining), 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (expired || one_hz || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // prog_sync and start_timer on the same edge
        prog_sync      = 1'b1;
        time_param_sel = 2'b11;
        start_timer    = 1'b1;
        interval       = 2'b00;
        step();
        prog_sync   = 1'b0;
        start_timer = 1'b0;
        check("same_edge_busy", int'(busy), 0);
        check("same_edge_rem", int'(remaining), 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (expired || busy) cnt++;
        end
        check("same_edge_quiet", cnt, 0);

        // Asynchronous reset mid-count, then defaults restored
        program_reg(2'b00, 9);
        start(2'b00);
        check("pre_reset_rem", int'(remaining), 9);
        step(); step(); step(); step(); step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        reset_n = 1'b1;
        step();
        start(2'b00);
        check("post_reset_base_rem", int'(remaining), 6);
        wait_expire("post_reset_base", 24, 6);
        start(2'b10);
        check("post_reset_yel_rem", int'(remaining), 2);
        wait_expire("post_reset_yel", 8, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/traffic_interval_timer.md
# traffic_interval_timer

Programmable interval timer and configuration controller for the traffic-light sequencer. It holds the three programmable phase durations (base, extended, yellow) and runs a seconds-resolution countdown. When the sequencer requests an interval, the block returns a one-cycle `expired` pulse once the selected duration has elapsed. It sits between the sequencer's `interval`/`start_timer`/`expired` interface and the synchronised programming inputs.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per one-second tick, ≥2.
- `VAL_W`, default 4: width of duration values, in seconds.
- `T_BASE`, default 6: reset value of the base interval.
- `T_EXT`, default 3: reset value of the extended interval.
- `T_YEL`, default 2: reset value of the yellow interval.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `prog_sync`  in  1  write strobe for a duration register; already synchronised.
- `time_param_sel`  in  2  register select: 00 base, 01 extended, 10 yellow, 11 reserved.
- `time_value`  in  VAL_W  duration to program, in seconds.
- `start_timer`  in  1  one-cycle request to load and start a countdown.
- `interval`  in  2  duration select for the start: 00 base, 01 extended, 10 yellow, 11 treated as base.
- `expired`  out  1  one-cycle pulse when the countdown completes.
- `one_hz`  out  1  one-cycle tick pulse; valid only while counting.
- `remaining`  out  VAL_W  seconds left in the current countdown.
- `busy`  out  1  high while counting.

## Operation
- Duration registers:
  - Reset to T_BASE, T_EXT and T_YEL.
  - On an edge with `prog_sync`=1 and sel≠11, the register selected by `time_param_sel` takes `time_value`.
  - A `time_value` of 0 writes the parameter default for that register instead.
  - sel=11 writes nothing.
- States:
  - IDLE: `busy`=0, prescaler held at 0.
  - COUNT: `busy`=1, prescaler runs.
  - EXPIRE: `expired`=1 for exactly one cycle.
- Transitions, in priority order:
  1. `prog_sync`=1 → IDLE from any state. `remaining` is cleared, the prescaler is cleared and `expired` is not pulsed. A `start_timer` on the same edge is ignored.
  2. `start_timer`=1 → COUNT from any state. `remaining` loads the selected register and the prescaler is cleared. This is a restart if already counting; a completion on the same edge is dropped.
  3. COUNT with prescaler=TICK_DIV-1 → prescaler wraps to 0, `one_hz` pulses, `remaining` decrements. If `remaining` was 1 it becomes 0 and the state goes to EXPIRE.
  4. EXPIRE → IDLE.
- `remaining` is never loaded with 0, because registers cannot hold 0. There is no underflow.
- A write to a register during COUNT does not alter an in-flight count; rule 1 aborts the count anyway.
- Reset values: `expired`=0, `one_hz`=0, `remaining`=0, `busy`=0, state IDLE, prescaler 0.

## Timing
- All outputs are registered (Moore); there are no combinational input-to-output paths.
- A start on edge E0 with duration N:
  - `busy` is high from E0.
  - `remaining` equals N after E0.
  - `expired` is high for the single cycle after edge E0+N·TICK_DIV.
  - `busy` falls on that same edge.
- `one_hz` pulses are spaced exactly TICK_DIV cycles apart, starting TICK_DIV cycles after the start edge.
- A programming write is visible to a start on the next edge.
- Holding `start_timer` high reloads on every cycle, so the count never expires. Requesters must pulse it.
- `reset_n` low clears all state and outputs immediately, independent of `clk`, including mid-count and during EXPIRE.
- Duration registers also return to their defaults on reset.

## Structure
- Shared package `traffic_pkg`:
  - interval codes: INT_BASE, INT_EXT, INT_YEL
  - parameter-select codes
  - the default durations
  - the timer state enum {IDLE, COUNT, EXPIRE}
- One sub-module, `tick_prescaler`:
  - clearable modulo-TICK_DIV counter with an enable input
  - emits the one-cycle tick
  - width is $clog2(TICK_DIV)
- The top level holds the three duration registers, the write-priority logic, the down-counter and the FSM.

## Test plan
All scenarios use TICK_DIV=4.
- Start test: after reset, pulse `start_timer` with `interval`=00 → `remaining` steps 6→1, `expired` is high for exactly one cycle, 24 cycles after the start edge, and `busy` then drops.
- Programming test: `prog_sync` with sel=10, value=5, then start with `interval`=10 → `expired` fires 20 cycles later.
- Default and reserved writes: program sel=01 with value 0, then start 01 → 12-cycle expiry (default 3 restored). A write with sel=11 changes no register.
- Restart: pulse start with `interval`=01 while `remaining`=2 → `remaining` reloads to 3, `expired` fires 12 cycles after the restart, with no earlier pulse.
- Abort: `prog_sync` mid-count → `busy`=0 and `remaining`=0 on the next edge, and `expired` never pulses. `prog_sync` and `start_timer` on the same edge → the timer stays IDLE.
- Reset: drive `reset_n` low between edges mid-count → all outputs go to 0 immediately. After release, a base start expires in 24 cycles, showing the defaults were restored.
